// File: rtl/gpio_irq_device.sv
// rtl/gpio_irq_device.sv - GPIO block with synchronised inputs, edge-detect pending flags and a level irq.
module gpio_irq_device #(
    parameter int          PINS        = 16,
    parameter logic [15:0] DEVICE_ID   = 16'h0,
    parameter logic [7:0]  DEVICE_TYPE = 8'h8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            cpu_clock,
    input  logic            reset,
    input  logic            write_enable,
    input  logic            is_control,
    input  logic [7:0]      short_address,
    input  logic [15:0]     cpu_data_in,
    output logic [15:0]     cpu_data_out,
    input  logic [PINS-1:0] gpio_in,
    output logic [PINS-1:0] gpio_out,
    output logic [PINS-1:0] gpio_config,
    output logic            irq
);

    logic [PINS-1:0] sync_chain [SYNC_STAGES];
    logic [PINS-1:0] s;
    logic [PINS-1:0] prev;
    logic [PINS-1:0] rise_en;
    logic [PINS-1:0] fall_en;
    logic [PINS-1:0] pending;
    logic            irq_enable;
    logic [2:0]      warm_count;
    logic            warm;

    logic [5:0]      addr;
    logic [3:0]      group;
    logic [1:0]      word;
    logic            wr;
    logic [PINS-1:0] wmask;
    logic [PINS-1:0] wdata;
    logic [PINS-1:0] rise;
    logic [PINS-1:0] fall;
    logic [PINS-1:0] clr;
    logic [15:0]     rdata;
    logic [1:0]      unused_addr_bits;

    assign addr             = short_address[5:0];
    assign unused_addr_bits = short_address[7:6];
    assign group            = addr[5:2];
    assign word             = addr[1:0];
    assign wr               = is_control & write_enable;
    assign s                = sync_chain[SYNC_STAGES-1];
    assign warm             = (warm_count == 3'(SYNC_STAGES + 1));

    function automatic logic [15:0] word_of(input logic [PINS-1:0] v, input logic [1:0] w);
        logic [63:0] p;
        p = 64'(v);
        return p[{w, 4'b0000} +: 16];
    endfunction

    // Per-pin view of the addressed 16-bit word; pins past PINS simply do not exist here.
    always_comb begin
        wmask = '0;
        wdata = '0;
        for (int i = 0; i < PINS; i++) begin
            wmask[i] = ((i / 16) == int'(word));
            wdata[i] = wmask[i] & cpu_data_in[i % 16];
        end
    end

    assign rise = warm ? (s & ~prev & rise_en) : '0;
    assign fall = warm ? (~s & prev & fall_en) : '0;
    assign clr  = (wr && group == 4'h6) ? wdata : '0;

    always_comb begin
        rdata = 16'h0;
        case (group)
            4'h0: begin
                case (word)
                    2'd0:    rdata = DEVICE_ID;
                    2'd1:    rdata = {6'(PINS - 1), 1'b1, irq, DEVICE_TYPE};
                    2'd2:    rdata = {15'h0, irq_enable};
                    default: rdata = 16'h0;
                endcase
            end
            4'h1:    rdata = word_of(gpio_config, word);
            4'h2:    rdata = word_of(gpio_out, word);
            4'h3:    rdata = word_of(s, word);
            4'h4:    rdata = word_of(rise_en, word);
            4'h5:    rdata = word_of(fall_en, word);
            4'h6:    rdata = word_of(pending, word);
            default: rdata = 16'h0;
        endcase
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
            prev       <= '0;
            warm_count <= '0;
        end else begin
            sync_chain[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            prev <= s;
            // Holds off edge detection until prev has caught up with a pin held high through reset.
            if (!warm) begin
                warm_count <= warm_count + 3'd1;
            end
        end
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            cpu_data_out <= 16'h0;
            gpio_out     <= '0;
            gpio_config  <= '0;
            rise_en      <= '0;
            fall_en      <= '0;
            pending      <= '0;
            irq_enable   <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr) begin
                case (group)
                    4'h0: if (word == 2'd2) irq_enable <= cpu_data_in[0];
                    4'h1: gpio_config <= (gpio_config & ~wmask) | wdata;
                    4'h2: gpio_out    <= (gpio_out & ~wmask) | wdata;
                    4'h4: rise_en     <= (rise_en & ~wmask) | wdata;
                    4'h5: fall_en     <= (fall_en & ~wmask) | wdata;
                    4'h7: gpio_out    <= gpio_out ^ wdata;
                    default: ;
                endcase
            end
            // New edges are ORed in after the clear so a coincident edge keeps the flag set.
            pending      <= (pending & ~clr) | rise | fall;
            irq          <= irq_enable & (|pending);
            cpu_data_out <= is_control ? rdata : 16'h0;
        end
    end

endmodule

// File: tb/tb_gpio_irq_device.sv
// tb/tb_gpio_irq_device.sv - directed self-checking bench for gpio_irq_device (16-pin and 40-pin builds).
module tb_gpio_irq_device;

    logic        cpu_clock;
    logic        reset;
    logic        write_enable;
    logic        is_control;
    logic [7:0]  short_address;
    logic [15:0] cpu_data_in;
    logic [15:0] gpio_in;

    logic [15:0] data16;
    logic [15:0] gpio_out16;
    logic [15:0] gpio_config16;
    logic        irq16;

    logic [15:0] data40;
    logic [39:0] gpio_in40;
    logic [39:0] gpio_out40;
    logic [39:0] gpio_config40;
    logic        irq40;

    int tests_run;
    int tests_failed;

    assign gpio_in40 = {24'h0, gpio_in};

    gpio_irq_device #(.PINS(16)) dut16 (
        .cpu_clock(cpu_clock), .reset(reset), .write_enable(write_enable),
        .is_control(is_control), .short_address(short_address), .cpu_data_in(cpu_data_in),
        .cpu_data_out(data16), .gpio_in(gpio_in), .gpio_out(gpio_out16),
        .gpio_config(gpio_config16), .irq(irq16)
    );

    gpio_irq_device #(.PINS(40)) dut40 (
        .cpu_clock(cpu_clock), .reset(reset), .write_enable(write_enable),
        .is_control(is_control), .short_address(short_address), .cpu_data_in(cpu_data_in),
        .cpu_data_out(data40), .gpio_in(gpio_in40), .gpio_out(gpio_out40),
        .gpio_config(gpio_config40), .irq(irq40)
    );

    initial begin
        cpu_clock = 1'b0;
        forever #5 cpu_clock = ~cpu_clock;
    end

    task automatic idle(input int n);
        is_control   = 1'b0;
        write_enable = 1'b0;
        repeat (n) @(posedge cpu_clock);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        is_control    = 1'b1;
        write_enable  = 1'b1;
        short_address = a;
        cpu_data_in   = d;
        @(posedge cpu_clock);
        #1;
        is_control    = 1'b0;
        write_enable  = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] d16, output logic [15:0] d40);
        is_control    = 1'b1;
        write_enable  = 1'b0;
        short_address = a;
        @(posedge cpu_clock);
        #1;
        d16 = data16;
        d40 = data40;
        is_control = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] r16, r40;
        reset = 1'b1; gpio_in = 16'hFFFF;
        is_control = 1'b0; write_enable = 1'b0; short_address = 8'h0; cpu_data_in = 16'h0;
        repeat (3) @(posedge cpu_clock);
        #1;
        tests_run++; if ({data16, gpio_out16, gpio_config16, irq16} !== 49'h0) begin tests_failed++; $display("FAIL reset_outputs: got %h expected 0", {data16, gpio_out16, gpio_config16, irq16}); end
        reset = 1'b0;
        bus_write(8'h10, 16'hFFFF);
        idle(6);
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0000) begin tests_failed++; $display("FAIL warmup_pending: got %h expected 0000", r16); end
        tests_run++; if (irq16 !== 1'b0) begin tests_failed++; $display("FAIL warmup_irq: got %b expected 0", irq16); end
        bus_read(8'h01, r16, r40);
        tests_run++; if (r16 !== 16'h3E08) begin tests_failed++; $display("FAIL info_word: got %h expected 3e08", r16); end
        bus_read(8'h00, r16, r40);
        tests_run++; if (r16 !== 16'h0000) begin tests_failed++; $display("FAIL device_id: got %h expected 0000", r16); end
    endtask

    task automatic test_rise_irq;
        logic [15:0] r16, r40;
        bus_write(8'h10, 16'h0001);
        bus_write(8'h02, 16'h0001);
        gpio_in = 16'h0000;
        idle(5);
        gpio_in = 16'h0001;
        idle(2);
        tests_run++; if (irq16 !== 1'b0) begin tests_failed++; $display("FAIL rise_irq_edge2: got %b expected 0", irq16); end
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0000 || irq16 !== 1'b0) begin tests_failed++; $display("FAIL rise_edge3: got pend %h irq %b expected 0000 0", r16, irq16); end
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0001 || irq16 !== 1'b1) begin tests_failed++; $display("FAIL rise_edge4: got pend %h irq %b expected 0001 1", r16, irq16); end
        bus_write(8'h18, 16'h0001);
        tests_run++; if (irq16 !== 1'b1) begin tests_failed++; $display("FAIL w1c_irq_hold: got %b expected 1", irq16); end
        idle(1);
        tests_run++; if (irq16 !== 1'b0) begin tests_failed++; $display("FAIL w1c_irq_drop: got %b expected 0", irq16); end
    endtask

    task automatic test_set_wins;
        logic [15:0] r16, r40;
        bus_write(8'h14, 16'h0004);
        gpio_in = 16'h0005;
        idle(5);
        gpio_in = 16'h0001;
        idle(2);
        bus_write(8'h18, 16'h0004);
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0004) begin tests_failed++; $display("FAIL set_wins: got %h expected 0004", r16); end
        bus_write(8'h18, 16'h0000);
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0004 || irq16 !== 1'b1) begin tests_failed++; $display("FAIL w1c_zero: got pend %h irq %b expected 0004 1", r16, irq16); end
        bus_write(8'h18, 16'h0004);
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0000 || irq16 !== 1'b0) begin tests_failed++; $display("FAIL w1c_clear: got pend %h irq %b expected 0000 0", r16, irq16); end
    endtask

    task automatic test_toggle;
        logic [15:0] r16, r40;
        bus_write(8'h08, 16'h00F0);
        tests_run++; if (gpio_out16 !== 16'h00F0) begin tests_failed++; $display("FAIL out_write: got %h expected 00f0", gpio_out16); end
        bus_write(8'h1C, 16'h0FF0);
        tests_run++; if (gpio_out16 !== 16'h0F00) begin tests_failed++; $display("FAIL toggle: got %h expected 0f00", gpio_out16); end
        bus_read(8'h1C, r16, r40);
        tests_run++; if (r16 !== 16'h0000) begin tests_failed++; $display("FAIL toggle_read: got %h expected 0000", r16); end
        bus_read(8'h08, r16, r40);
        tests_run++; if (r16 !== 16'h0F00) begin tests_failed++; $display("FAIL out_read: got %h expected 0f00", r16); end
        bus_write(8'h04, 16'h8001);
        tests_run++; if (gpio_config16 !== 16'h8001) begin tests_failed++; $display("FAIL config_write: got %h expected 8001", gpio_config16); end
    endtask

    task automatic test_wide_pins;
        logic [15:0] r16, r40;
        bus_write(8'h0A, 16'hFFFF);
        tests_run++; if (gpio_out40 !== 40'hFF_0000_0F00) begin tests_failed++; $display("FAIL wide_out: got %h expected ff00000f00", gpio_out40); end
        tests_run++; if (gpio_out16 !== 16'h0F00) begin tests_failed++; $display("FAIL narrow_out_word2: got %h expected 0f00", gpio_out16); end
        bus_read(8'h0A, r16, r40);
        tests_run++; if (r40 !== 16'h00FF || r16 !== 16'h0000) begin tests_failed++; $display("FAIL wide_read_w2: got %h/%h expected 00ff/0000", r40, r16); end
        bus_read(8'h0B, r16, r40);
        tests_run++; if (r40 !== 16'h0000) begin tests_failed++; $display("FAIL wide_read_w3: got %h expected 0000", r40); end
        bus_read(8'h01, r16, r40);
        tests_run++; if (r40 !== 16'h9E08) begin tests_failed++; $display("FAIL wide_info: got %h expected 9e08", r40); end
        bus_read(8'h48, r16, r40);
        tests_run++; if (r16 !== 16'h0F00) begin tests_failed++; $display("FAIL addr_alias: got %h expected 0f00", r16); end
    endtask

    task automatic test_async_reset;
        logic [15:0] r16, r40;
        bus_write(8'h08, 16'hAAAA);
        gpio_in = 16'h0000;
        idle(4);
        gpio_in = 16'h0001;
        idle(5);
        tests_run++; if (irq16 !== 1'b1 || gpio_out16 !== 16'hAAAA) begin tests_failed++; $display("FAIL pre_reset: got irq %b out %h expected 1 aaaa", irq16, gpio_out16); end
        #3;
        reset = 1'b1;
        #1;
        tests_run++; if (irq16 !== 1'b0 || gpio_out16 !== 16'h0000 || gpio_config16 !== 16'h0000) begin tests_failed++; $display("FAIL async_reset: got irq %b out %h cfg %h expected 0 0000 0000", irq16, gpio_out16, gpio_config16); end
        tests_run++; if (gpio_out40 !== 40'h0) begin tests_failed++; $display("FAIL async_reset_wide: got %h expected 0", gpio_out40); end
        @(posedge cpu_clock);
        #1;
        reset = 1'b0;
        idle(2);
        bus_read(8'h18, r16, r40);
        tests_run++; if (r16 !== 16'h0000) begin tests_failed++; $display("FAIL reset_pending: got %h expected 0000", r16); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_rise_irq();
        test_set_wins();
        test_toggle();
        test_wide_pins();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
